// File: rtl/vga_sync_monitor.sv
// rtl/vga_sync_monitor.sv - VGA sync receiver: coordinate recovery, period measurement, lock/err
// Optional build macro: PIXEL_CHECKSUM_EN adds the frame_sum pixel checksum output.
module vga_sync_monitor #(
   parameter int CW       = 10,
   parameter int H_TOTAL  = 800,
   parameter int V_TOTAL  = 525,
   parameter int H_OFS    = 144,
   parameter int V_OFS    = 35,
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480
) (
   input  logic          mclk,
   input  logic          reset,
   input  logic          pix_en,
   input  logic          hsync,
   input  logic          vsync,
   input  logic [7:0]    rgb,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          active,
   output logic          locked,
   output logic [CW-1:0] h_total,
   output logic [CW-1:0] v_total,
   output logic          frame_done,
`ifdef PIXEL_CHECKSUM_EN
   output logic [15:0]   frame_sum,
`endif
   output logic          err
);

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

   localparam logic [CW-1:0] CMAX    = '1;
   localparam logic [CW-1:0] H_TOT_C = CW'(H_TOTAL);
   localparam logic [CW-1:0] V_TOT_C = CW'(V_TOTAL);
   localparam logic [CW-1:0] H_OFS_C = CW'(H_OFS);
   localparam logic [CW-1:0] V_OFS_C = CW'(V_OFS);
   localparam logic [CW-1:0] H_END_C = CW'(H_OFS + H_ACTIVE);
   localparam logic [CW-1:0] V_END_C = CW'(V_OFS + V_ACTIVE);

   state_t        state;
   logic          hs_q;
   logic          vs_q;
   logic [CW-1:0] hcnt;
   logic [CW-1:0] lcnt;
   logic          line_bad;

   logic          hs_fall;
   logic          vs_fall;
   logic [CW-1:0] h_inc;
   logic [CW-1:0] l_inc;
   logic [CW-1:0] v_meas;
   logic          h_bad;
   logic          v_bad;
   logic          line_bad_now;
   logic          active_c;

   // Edge detection and saturating next-count values for the current tick
   always_comb begin
      hs_fall      = pix_en & hs_q & ~hsync;
      vs_fall      = pix_en & vs_q & ~vsync;
      h_inc        = (hcnt == CMAX) ? CMAX : hcnt + 1'b1;
      l_inc        = (lcnt == CMAX) ? CMAX : lcnt + 1'b1;
      // A line that ends on the vsync tick still belongs to the frame being closed
      v_meas       = hs_fall ? l_inc : lcnt;
      h_bad        = hs_fall & (h_inc != H_TOT_C);
      v_bad        = (v_meas != V_TOT_C);
      line_bad_now = line_bad | h_bad;
      active_c     = (hcnt >= H_OFS_C) && (hcnt < H_END_C) &&
                     (lcnt >= V_OFS_C) && (lcnt < V_END_C);
   end

   // Sync sampling, pixel/line counters and period capture
   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         hs_q       <= 1'b1;
         vs_q       <= 1'b1;
         hcnt       <= '0;
         lcnt       <= '0;
         h_total    <= '0;
         v_total    <= '0;
         line_bad   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= vs_fall;
         if (pix_en) begin
            hs_q <= hsync;
            vs_q <= vsync;
            hcnt <= hs_fall ? '0 : h_inc;
            if (hs_fall)
               h_total <= h_inc;
            if (vs_fall) begin
               v_total <= v_meas;
               lcnt    <= '0;
            end else if (hs_fall) begin
               lcnt    <= l_inc;
            end
            if (vs_fall)
               line_bad <= 1'b0;
            else if (h_bad)
               line_bad <= 1'b1;
         end
      end
   end

   // Lock state machine with registered locked/err outputs
   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         state  <= SEARCH;
         locked <= 1'b0;
         err    <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            SEARCH: begin
               if (vs_fall)
                  state <= MEASURE;
            end
            MEASURE: begin
               if (vs_fall && !v_bad && !line_bad_now) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
               end
            end
            LOCKED: begin
               // Simultaneous line and frame mismatches produce a single err pulse
               if (h_bad || (vs_fall && v_bad)) begin
                  err    <= 1'b1;
                  state  <= MEASURE;
                  locked <= 1'b0;
               end
            end
            default: begin
               state  <= SEARCH;
               locked <= 1'b0;
            end
         endcase
      end
   end

   // Visible-area coordinates, one mclk behind the counters
   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         active <= 1'b0;
         x      <= '0;
         y      <= '0;
      end else begin
         active <= active_c;
         x      <= active_c ? hcnt - H_OFS_C : '0;
         y      <= active_c ? lcnt - V_OFS_C : '0;
      end
   end

`ifdef PIXEL_CHECKSUM_EN
   logic [15:0] acc;

   // Per-frame sum of visible pixel colours, published on each vsync fall
   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         acc       <= '0;
         frame_sum <= '0;
      end else if (vs_fall) begin
         frame_sum <= acc;
         acc       <= '0;
      end else if (pix_en && active) begin
         acc       <= acc + {8'h00, rgb};
      end
   end
`else
   logic unused_rgb;
   assign unused_rgb = ^rgb;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb/tb_vga_sync_monitor.sv - scoreboard bench for vga_sync_monitor on scaled-down timing
module tb_vga_sync_monitor;

   localparam int P_CW = 10;
   localparam int P_HT = 50;
   localparam int P_VT = 20;
   localparam int P_HO = 12;
   localparam int P_VO = 3;
   localparam int P_HA = 32;
   localparam int P_VA = 14;
   localparam int HS_W = 6;
   localparam int NPROBE = 7;

   logic            mclk;
   logic            reset;
   logic            pix_en;
   logic            hsync;
   logic            vsync;
   logic [7:0]      rgb;
   logic [P_CW-1:0] x;
   logic [P_CW-1:0] y;
   logic            active;
   logic            locked;
   logic [P_CW-1:0] h_total;
   logic [P_CW-1:0] v_total;
   logic            frame_done;
   logic            err;
`ifdef PIXEL_CHECKSUM_EN
   logic [15:0]     frame_sum;
`endif

   vga_sync_monitor #(
      .CW(P_CW), .H_TOTAL(P_HT), .V_TOTAL(P_VT), .H_OFS(P_HO),
      .V_OFS(P_VO), .H_ACTIVE(P_HA), .V_ACTIVE(P_VA)
   ) dut (
      .mclk(mclk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
      .rgb(rgb), .x(x), .y(y), .active(active), .locked(locked),
      .h_total(h_total), .v_total(v_total), .frame_done(frame_done),
`ifdef PIXEL_CHECKSUM_EN
      .frame_sum(frame_sum),
`endif
      .err(err)
   );

   typedef struct { int h; int v; int lk; int sum; } frame_exp_t;
   typedef struct { int h; } err_exp_t;
   typedef struct { int x; int y; int a; } probe_exp_t;

   frame_exp_t frame_q[$];
   err_exp_t   err_q[$];
   probe_exp_t probe_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int probe_cnt = 0;
   int probe_seen = 0;
   bit probe_on = 0;

   // Probe table: line, tick within line, expected x, y, active
   int pl[NPROBE] = '{3,  3,  3,  16, 17, 2,  10};
   int pk[NPROBE] = '{12, 43, 44, 43, 20, 20, 25};
   int px[NPROBE] = '{0,  31, 0,  31, 0,  0,  13};
   int py[NPROBE] = '{0,  0,  0,  13, 0,  0,  7};
   int pa[NPROBE] = '{1,  1,  0,  1,  0,  0,  1};

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push_frame(input int h, input int v, input int lk, input int sum);
      frame_exp_t e;
      e.h = h; e.v = v; e.lk = lk; e.sum = sum;
      frame_q.push_back(e);
   endtask

   task automatic push_err(input int h);
      err_exp_t e;
      e.h = h;
      err_q.push_back(e);
   endtask

   task automatic tick(input bit hs, input bit vs);
      @(negedge mclk);
      pix_en = 1'b1;
      hsync  = hs;
      vsync  = vs;
      @(posedge mclk);
      @(negedge mclk);
      pix_en = 1'b0;
      @(posedge mclk);
   endtask

   task automatic line(input int len, input bit vs_low, input int n_ticks, input int lidx);
      probe_exp_t e;
      for (int k = 0; k < n_ticks && k < len; k++) begin
         tick(k >= HS_W, !vs_low);
         if (probe_on) begin
            for (int p = 0; p < NPROBE; p++) begin
               if (pl[p] == lidx && pk[p] == k) begin
                  e.x = px[p]; e.y = py[p]; e.a = pa[p];
                  probe_q.push_back(e);
                  probe_cnt++;
               end
            end
         end
      end
   endtask

   task automatic frame(input int short_idx, input int hold_idx, input int n_lines);
      for (int l = 0; l < n_lines; l++) begin
         if (l == hold_idx) begin
            for (int i = 0; i < 1100; i++) tick(1'b1, 1'b1);
         end else begin
            line((l == short_idx) ? P_HT - 1 : P_HT, l < 2, P_HT, l);
         end
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_x"}, int'(x), 0);
      chk({tag, "_y"}, int'(y), 0);
      chk({tag, "_active"}, int'(active), 0);
      chk({tag, "_locked"}, int'(locked), 0);
      chk({tag, "_h_total"}, int'(h_total), 0);
      chk({tag, "_v_total"}, int'(v_total), 0);
      chk({tag, "_frame_done"}, int'(frame_done), 0);
      chk({tag, "_err"}, int'(err), 0);
   endtask

   // Monitor: pops expectations whenever the DUT presents a pulse or a probe is due
   always @(negedge mclk) begin
      frame_exp_t fe;
      err_exp_t   ee;
      probe_exp_t pe;
      if (!reset) begin
         if (frame_done) begin
            if (frame_q.size() == 0) begin
               chk("frame_done_unexpected", 1, 0);
            end else begin
               fe = frame_q.pop_front();
               chk("frame_h_total", int'(h_total), fe.h);
               chk("frame_v_total", int'(v_total), fe.v);
               chk("frame_locked", int'(locked), fe.lk);
`ifdef PIXEL_CHECKSUM_EN
               chk("frame_sum", int'(frame_sum), fe.sum);
`endif
            end
         end
         if (err) begin
            if (err_q.size() == 0) begin
               chk("err_unexpected", 1, 0);
            end else begin
               ee = err_q.pop_front();
               chk("err_h_total", int'(h_total), ee.h);
               chk("err_locked", int'(locked), 0);
            end
         end
         while (probe_seen < probe_cnt) begin
            pe = probe_q.pop_front();
            probe_seen++;
            chk("probe_x", int'(x), pe.x);
            chk("probe_y", int'(y), pe.y);
            chk("probe_active", int'(active), pe.a);
         end
      end
   end

   initial begin
      #1000000;
      chk("watchdog_expired", 1, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      reset  = 1'b1;
      pix_en = 1'b0;
      hsync  = 1'b1;
      vsync  = 1'b1;
      rgb    = 8'h01;
      repeat (3) @(posedge mclk);
      #1;
      chk_all_zero("reset");
      @(negedge mclk);
      reset = 1'b0;

      // F1: first vsync fall right after reset, counters were still 0
      push_frame(1, 1, 0, 0);
      frame(-1, -1, P_VT);
      // F2: one clean frame measured -> lock; coordinate probes
      push_frame(P_HT, P_VT, 1, 448);
      probe_on = 1'b1;
      frame(-1, -1, P_VT);
      probe_on = 1'b0;
      // F3: line 10 shortened by one tick -> err at start of line 11
      push_frame(P_HT, P_VT, 1, 448);
      push_err(P_HT - 1);
      frame(10, -1, P_VT);
      // F4: closing the bad frame keeps MEASURE
      push_frame(P_HT, P_VT, 0, 448);
      frame(-1, -1, P_VT);
      // F5: relocked, then reset mid-line
      push_frame(P_HT, P_VT, 1, 448);
      frame(-1, -1, 11);
      line(P_HT, 1'b0, 20, 11);
      #3;
      reset = 1'b1;
      #1;
      chk_all_zero("async_reset");
      @(negedge mclk);
      @(posedge mclk);
      @(negedge mclk);
      reset = 1'b0;
      // F6: back in SEARCH, no err on the first vsync fall
      push_frame(1, 1, 0, 0);
      frame(-1, -1, P_VT);
      // F7: clean frame -> lock
      push_frame(P_HT, P_VT, 1, 448);
      frame(-1, -1, P_VT);
      // F8: hsync absent for 1100 ticks -> saturated period, err
      push_frame(P_HT, P_VT, 1, 448);
      push_err((1 << P_CW) - 1);
      frame(-1, 5, P_VT);
      // F9: frame with one missing line measured as 19 lines
      push_frame(P_HT, P_VT - 1, 0, 448);
      frame(-1, -1, P_VT);
      // F10: relock seen on this vsync fall
      push_frame(P_HT, P_VT, 1, 448);
      frame(-1, -1, 3);
      repeat (10) @(posedge mclk);

      chk("frames_left", frame_q.size(), 0);
      chk("errs_left", err_q.size(), 0);
      chk("probes_left", probe_cnt - probe_seen, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the VGA timing generator. Samples HSYNC/VSYNC and, optionally, the 8-bit pixel colour bus.
- Recovers pixel coordinates, measures line and frame periods, and reports lock and timing errors.
- Used in the on-board self-test next to the renderer and as a bench checker for the sync generator.

Parameters:
- CW, 10, width of coordinate and period counters.
- H_TOTAL, 800, expected pix ticks per line.
- V_TOTAL, 525, expected lines per frame.
- H_OFS, 144, ticks from hsync falling edge to first active pixel (sync + back porch).
- V_OFS, 35, lines from vsync falling edge to first active line.
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.

Ports:
- mclk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pix_en  in  1  pixel-tick enable (mclk/2); all sampling and counting happens only when pix_en=1.
- hsync  in  1  active-low horizontal sync.
- vsync  in  1  active-low vertical sync.
- rgb  in  8  pixel colour {R3,G3,B2}.
- x  out  CW  recovered column, 0..H_ACTIVE-1.
- y  out  CW  recovered row, 0..V_ACTIVE-1.
- active  out  1  x/y are inside the visible area.
- locked  out  1  timing matches the parameters.
- h_total  out  CW  last measured line period.
- v_total  out  CW  last measured frame period in lines.
- frame_done  out  1  one-mclk pulse on each vsync falling edge.
- err  out  1  one-mclk pulse on a period mismatch while locked.

Behaviour:
- Reset: all outputs 0, counters 0, state SEARCH, sync sample registers 1 (idle).
- Sampling: on each pix_en tick, hsync and vsync are registered into hs_q and vs_q. A falling edge is hs_q=1 while the current input is 0; vsync is handled the same way. All updates below occur on that same tick.
- hcnt:
  - Cleared to 0 on an hsync fall; otherwise +1.
  - Saturates at 2^CW-1.
  - On an hsync fall, h_total <= hcnt+1, also saturating.
- lcnt:
  - Increments on each hsync fall.
  - On a vsync fall, v_total <= lcnt+1 if hsync also fell on this tick, else lcnt; then lcnt <= 0.
  - vsync handling has priority over the increment.
- Coordinates:
  - active=1 iff H_OFS<=hcnt<H_OFS+H_ACTIVE and V_OFS<=lcnt<V_OFS+V_ACTIVE, evaluated on the registered counter values.
  - x=hcnt-H_OFS and y=lcnt-V_OFS when active, else both 0.
  - Outputs are registered, so their latency is one mclk after the counter update.
- line_bad: sticky flag, set when any hsync fall gives hcnt+1 != H_TOTAL; cleared on a vsync fall.
- FSM:
  - SEARCH: on a vsync fall -> MEASURE (clear line_bad).
  - MEASURE: on a vsync fall, go to LOCKED if the captured frame has v_total==V_TOTAL and line_bad is clear; else stay in MEASURE.
  - LOCKED: an hsync fall with wrong period, or a vsync fall with wrong v_total, pulses err for one mclk and goes to MEASURE. In the same-tick case, err pulses once.
  - locked=1 only in LOCKED.
- frame_done: pulses on every vsync fall in every state.
- Reset mid-frame: immediate return to reset state. Lock needs one full clean frame after the first observed vsync fall.
- Absent hsync: hcnt holds at 2^CW-1. The next hsync fall reports h_total=2^CW-1 and causes a mismatch.

Optional Feature:
- Macro: PIXEL_CHECKSUM_EN.
- Defined:
  - Adds output frame_sum [15:0].
  - A 16-bit accumulator adds zero-extended rgb on every pix tick with active=1, wrapping mod 2^16.
  - On a vsync fall, frame_sum <= accumulator and the accumulator clears.
  - frame_sum resets to 0.
- Undefined: no port, no accumulator logic.

Test Plan:
- Nominal 800x525 timing (hsync 96 low, vsync 2 lines low, aligned edges), 3 frames -> locked=1 after the 2nd vsync fall; h_total=800, v_total=525; frame_done pulses once per frame.
- Locked, then one line shortened to 799 -> err pulses once on that hsync fall, h_total=799, locked=0; relock after the next clean full frame.
- Locked, sample hcnt=144 on line 35 -> x=0, y=0, active=1. hcnt=783 -> x=639. hcnt=784 -> active=0, x=0. Line 515 -> active=0.
- Assert reset mid-line on line 200 -> all outputs 0 asynchronously; after release, state is SEARCH and there is no err pulse.
- Hold hsync high for 1100 ticks, then fall -> h_total=1023, err=1 if previously locked.
- PIXEL_CHECKSUM_EN with rgb=8'h01 constant, nominal frame -> frame_sum=16'hB000 (307200 mod 65536).
